// File: rtl/sram_port_arbiter.sv
// Two 32-bit requesters sharing one 16-bit SRAM. Each word access runs as a low
// half-word phase followed by a high half-word phase, with round-robin arbitration.
module sram_port_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        busy,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES);

  state_t      state, next_state;
  logic [2:0]  cnt;
  logic        grant, last_grant, we_q;
  logic [16:0] widx;
  logic [31:0] wdata_q;
  logic [15:0] lo_q;
  logic        pick, any_req, in_phase, phase_end;
  logic [31:0] addr_pick;
  logic        dq_drive;
  logic [15:0] dq_out;

  // With both ports requesting, the port that did not win last time goes next.
  always_comb begin
    any_req   = m0_req | m1_req;
    pick      = (m0_req & m1_req) ? ~last_grant : m1_req;
    addr_pick = pick ? m1_addr : m0_addr;
    in_phase  = (state == LO) || (state == HI);
    phase_end = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = LO;
      LO:      if (phase_end) next_state = HI;
      HI:      if (phase_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are latched at grant so the requester may change them mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 3'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      widx       <= 17'd0;
      wdata_q    <= 32'd0;
      lo_q       <= 16'd0;
      m0_rdata   <= 32'd0;
      m1_rdata   <= 32'd0;
    end else begin
      cnt <= (in_phase && !phase_end) ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && any_req) begin
        grant   <= pick;
        we_q    <= pick ? m1_we : m0_we;
        widx    <= 17'((addr_pick - BASE_ADDR) >> 2);
        wdata_q <= pick ? m1_wdata : m0_wdata;
      end
      if (state == LO && phase_end && !we_q) lo_q <= SRAM_DQ;
      if (state == HI && phase_end && !we_q) begin
        if (grant) m1_rdata <= {SRAM_DQ, lo_q};
        else       m0_rdata <= {SRAM_DQ, lo_q};
      end
      if (state == DONE) last_grant <= grant;
    end
  end

  // The write strobe releases on the last cycle of a phase so data is held past WE_N rising.
  always_comb begin
    busy      = (state != IDLE);
    m0_done   = (state == DONE) && !grant;
    m1_done   = (state == DONE) && grant;
    SRAM_ADDR = in_phase ? {widx, (state == HI)} : 18'd0;
    SRAM_WE_N = !(in_phase && we_q && (!phase_end || (WAIT_CYCLES == 0)));
    SRAM_OE_N = !(in_phase && !we_q);
    dq_drive  = in_phase && we_q;
    dq_out    = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (WAIT_CYCLES 1, 0, 3) each on a small
// SRAM model; instance 0 is also checked against a word-level reference model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req [3];
  logic        m0_we [3];
  logic [31:0] m0_addr [3];
  logic [31:0] m0_wdata [3];
  logic [31:0] m0_rdata [3];
  logic        m0_done [3];
  logic        m1_req [3];
  logic        m1_we [3];
  logic [31:0] m1_addr [3];
  logic [31:0] m1_wdata [3];
  logic [31:0] m1_rdata [3];
  logic        m1_done [3];
  logic        busy [3];
  logic [17:0] sa [3];
  logic        we_n [3];
  logic        ub_n [3];
  logic        lb_n [3];
  logic        ce_n [3];
  logic        oe_n [3];

  int tests = 0;
  int fails = 0;

  // Reference model: SRAM contents as whole words, expected rdata per port, last winner.
  logic [31:0] mmem [int];
  logic [31:0] mrd [2];
  int          mlast;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire  [15:0] dq;
    logic [15:0] mem [256];

    sram_port_arbiter #(
      .BASE_ADDR  (32'd1024),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_req   (m0_req[g]),
      .m0_we    (m0_we[g]),
      .m0_addr  (m0_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_rdata (m0_rdata[g]),
      .m0_done  (m0_done[g]),
      .m1_req   (m1_req[g]),
      .m1_we    (m1_we[g]),
      .m1_addr  (m1_addr[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_rdata (m1_rdata[g]),
      .m1_done  (m1_done[g]),
      .busy     (busy[g]),
      .SRAM_DQ  (dq),
      .SRAM_ADDR(sa[g]),
      .SRAM_WE_N(we_n[g]),
      .SRAM_UB_N(ub_n[g]),
      .SRAM_LB_N(lb_n[g]),
      .SRAM_CE_N(ce_n[g]),
      .SRAM_OE_N(oe_n[g])
    );

    assign dq = !oe_n[g] ? mem[sa[g][7:0]] : 16'bz;
    always @(posedge clk) if (!we_n[g]) mem[sa[g][7:0]] <= dq;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int widx(logic [31:0] a);
    return int'(((a - 32'd1024) / 4) % 131072);
  endfunction

  function automatic logic [31:0] rd(int idx);
    return mmem.exists(idx) ? mmem[idx] : 32'd0;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(int i, int p, logic we, logic [31:0] addr, logic [31:0] wd);
    if (p == 0) begin
      m0_req[i] = 1'b1; m0_we[i] = we; m0_addr[i] = addr; m0_wdata[i] = wd;
    end else begin
      m1_req[i] = 1'b1; m1_we[i] = we; m1_addr[i] = addr; m1_wdata[i] = wd;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends the done cycle.
  task automatic waitDone(int i, bit early_drop, output int mask, output int cyc,
                          output int we_low, output int oe_low, output logic [17:0] addr_or);
    mask = 0; cyc = -1; we_low = 0; oe_low = 0; addr_or = 18'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!we_n[i]) we_low++;
      if (!oe_n[i]) oe_low++;
      if (!we_n[i] || !oe_n[i]) addr_or = addr_or | sa[i];
      if (m0_done[i] || m1_done[i]) begin
        mask = int'({m1_done[i], m0_done[i]});
        cyc = c;
        break;
      end
      @(posedge clk); #1;
      if (early_drop && c == 1) begin m0_req[i] = 1'b0; m1_req[i] = 1'b0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic commit(int p, logic we, logic [31:0] addr, logic [31:0] wd);
    if (we) mmem[widx(addr)] = wd;
    else    mrd[p] = rd(widx(addr));
    mlast = p;
    checkOutput("rdata_p0", m0_rdata[0], mrd[0]);
    checkOutput("rdata_p1", m1_rdata[0], mrd[1]);
  endtask

  task automatic runPair(bit r0, bit r1, logic we0, logic we1, logic [31:0] a0, logic [31:0] a1,
                         logic [31:0] d0, logic [31:0] d1);
    int first, n, mask, cyc, wl, ol, p;
    logic [17:0] ao;
    first = (r0 && r1) ? (mlast == 1 ? 0 : 1) : (r0 ? 0 : 1);
    n = (r0 && r1) ? 2 : 1;
    if (r0) applyStimulus(0, 0, we0, a0, d0);
    if (r1) applyStimulus(0, 1, we1, a1, d1);
    for (int k = 0; k < n; k++) begin
      p = (k == 0) ? first : 1 - first;
      waitDone(0, 1'b0, mask, cyc, wl, ol, ao);
      checkOutput("grant", mask, 1 << p);
      checkOutput("latency", cyc, 6);
      if (p == 0) begin commit(0, we0, a0, d0); m0_req[0] = 1'b0; end
      else        begin commit(1, we1, a1, d1); m1_req[0] = 1'b0; end
    end
    @(negedge clk);
    checkOutput("done_pulse", int'({m1_done[0], m0_done[0]}), 0);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m0_req[i] = 1'b0; m0_we[i] = 1'b0; m0_addr[i] = 32'd0; m0_wdata[i] = 32'd0;
      m1_req[i] = 1'b0; m1_we[i] = 1'b0; m1_addr[i] = 32'd0; m1_wdata[i] = 32'd0;
    end
    mrd[0] = 32'd0; mrd[1] = 32'd0; mlast = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int mask, cyc, wl, ol, w, r;
    logic [17:0] ao;
    logic [31:0] a0, a1, wd;
    logic w0, w1;

    doReset();
    @(negedge clk);
    checkOutput("rst_rdata0", m0_rdata[0], 32'd0);
    checkOutput("rst_rdata1", m1_rdata[0], 32'd0);
    checkOutput("rst_done", int'({m1_done[0], m0_done[0]}), 0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_addr", 32'(sa[0]), 32'd0);
    checkOutput("rst_strobes", 32'({we_n[0], oe_n[0], ub_n[0], lb_n[0], ce_n[0]}), 32'b11000);
    @(posedge clk); #1;

    runPair(1'b1, 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 32'd0);
    checkOutput("sram_lo", 32'(g_dut[0].mem[0]), 32'h0000BEEF);
    checkOutput("sram_hi", 32'(g_dut[0].mem[1]), 32'h0000DEAD);
    runPair(1'b1, 1'b0, 1'b0, 1'b0, 32'd1024, 32'd0, 32'd0, 32'd0);
    checkOutput("read_back", m0_rdata[0], 32'hDEADBEEF);

    // Both requests stay high: grants alternate starting with port 0 after reset.
    doReset();
    applyStimulus(0, 0, 1'b1, 32'd1032, 32'h11112222);
    applyStimulus(0, 1, 1'b1, 32'd1036, 32'h33334444);
    for (int k = 0; k < 3; k++) begin
      waitDone(0, 1'b0, mask, cyc, wl, ol, ao);
      checkOutput("rr_grant", mask, (k % 2 == 0) ? 1 : 2);
      checkOutput("rr_latency", cyc, 6);
      if (k % 2 == 0) commit(0, 1'b1, 32'd1032, 32'h11112222);
      else            commit(1, 1'b1, 32'd1036, 32'h33334444);
    end
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    @(negedge clk);
    checkOutput("rr_idle", 32'({busy[0], m1_done[0], m0_done[0]}), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 1 : ((i == 1) ? 0 : 3);
      wd = $urandom;
      applyStimulus(i, 0, 1'b1, 32'd1044, wd);
      waitDone(i, 1'b0, mask, cyc, wl, ol, ao);
      m0_req[i] = 1'b0;
      checkOutput("sweep_wr_latency", cyc, 2 * (w + 1) + 2);
      checkOutput("sweep_we_low", wl, (w == 0) ? 2 : 2 * w);
      checkOutput("sweep_addr", 32'(ao), 32'd11);
      if (i == 0) commit(0, 1'b1, 32'd1044, wd);
      @(posedge clk); #1;
      applyStimulus(i, 0, 1'b0, 32'd1044, 32'd0);
      waitDone(i, 1'b0, mask, cyc, wl, ol, ao);
      m0_req[i] = 1'b0;
      checkOutput("sweep_rd_latency", cyc, 2 * (w + 1) + 2);
      checkOutput("sweep_oe_low", ol, 2 * (w + 1));
      checkOutput("sweep_rdata", m0_rdata[i], wd);
      if (i == 0) commit(0, 1'b0, 32'd1044, 32'd0);
      @(posedge clk); #1;
    end

    // Out-of-range address wraps; the request is withdrawn after one cycle.
    applyStimulus(0, 1, 1'b1, 32'd1024 + 32'd524288, 32'h12345678);
    waitDone(0, 1'b1, mask, cyc, wl, ol, ao);
    checkOutput("wrap_done", mask, 2);
    checkOutput("wrap_latency", cyc, 6);
    checkOutput("wrap_addr", 32'(ao), 32'd1);
    commit(1, 1'b1, 32'd1024 + 32'd524288, 32'h12345678);
    checkOutput("wrap_sram", 32'({g_dut[0].mem[1], g_dut[0].mem[0]}), 32'h12345678);

    for (int t = 0; t < 16; t++) begin
      r  = int'($urandom_range(1, 3));
      a0 = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      a1 = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      w0 = ($urandom_range(0, 1) == 1) || !mmem.exists(widx(a0));
      w1 = ($urandom_range(0, 1) == 1) || !mmem.exists(widx(a1));
      runPair(r[0], r[1], w0, w1, a0, a1, $urandom, $urandom);
    end

    // Reset during the high phase of a write aborts at once with no done pulse.
    doReset();
    applyStimulus(0, 0, 1'b1, 32'd1224, 32'hCAFEF00D);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin @(posedge clk); #1; end
    end
    checkOutput("abort_pre_addr", 32'(sa[0]), 32'd101);
    checkOutput("abort_pre_we", 32'({busy[0], we_n[0]}), 32'b10);
    rst = 1'b0;
    #1;
    checkOutput("abort_strobes", 32'({we_n[0], oe_n[0]}), 32'b11);
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    checkOutput("abort_done", int'({m1_done[0], m0_done[0]}), 0);
    checkOutput("abort_addr", 32'(sa[0]), 32'd0);
    m0_req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mrd[0] = 32'd0; mrd[1] = 32'd0; mlast = 1;
    runPair(1'b1, 1'b0, 1'b0, 1'b0, 32'd1024, 32'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
